// File: rtl/ring_pkg.sv
// Shared packet layout, register address codes and widths for the ring node NIC.
// Packet bit 63 carries the virtual-channel (VC) bit.
package ring_pkg;

  localparam int PKT_W = 64;

  // Packet field positions.
  localparam int VC_BIT     = 63;
  localparam int DIR_BIT    = 62;
  localparam int HOP_HI     = 55;
  localparam int HOP_LO     = 48;
  localparam int SRC_HI     = 47;
  localparam int SRC_LO     = 32;
  localparam int PAYLOAD_HI = 31;
  localparam int PAYLOAD_LO = 0;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [1:0] {
    ADDR_IN_DATA  = 2'b00,
    ADDR_IN_STAT  = 2'b01,
    ADDR_OUT_DATA = 2'b10,
    ADDR_OUT_STAT = 2'b11
  } addr_e;

  function automatic logic vc_of(input pkt_t p);
    return p[VC_BIT];
  endfunction

endpackage

// File: rtl/ring_nic_fifo.sv
// DEPTH x W packet FIFO. Push is ignored when full and pop is ignored when empty,
// both judged on the state before the edge; simultaneous push and pop are both honoured.
module ring_nic_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // One extra pointer bit so occupancy wraps modulo 2*DEPTH.
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]  count;
  logic         do_push, do_pop;
  logic [W-1:0] mem_q [DEPTH];

  assign count   = wr_q - rd_q;
  assign full_o  = (count == FULL_CNT);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ring_nic.sv
// PE-side ring node interface: processor register port, output FIFO injecting into the router,
// input FIFO ejecting from it. Optional saturating statistics under `ifdef RING_NIC_STATS_EN.
module ring_nic
  import ring_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic [PKT_W-1:0] d_in,
  input  logic             nicEn,
  input  logic             nicWrEn,
  output logic [PKT_W-1:0] d_out,
  output logic             net_si,
  input  logic             net_ri,
  output logic [PKT_W-1:0] net_di,
  input  logic             net_so,
  output logic             net_ro,
  input  logic [PKT_W-1:0] net_do,
  input  logic             net_polarity
);

  logic rd_en, wr_en;
  logic wr_out, rd_in;
  logic out_full, out_empty, in_full, in_empty;
  pkt_t out_head, in_head;

  assign rd_en  = nicEn & ~nicWrEn;
  assign wr_en  = nicEn & nicWrEn;
  assign wr_out = wr_en & (addr_e'(addr) == ADDR_OUT_DATA);
  assign rd_in  = rd_en & (addr_e'(addr) == ADDR_IN_DATA);

  // A head whose VC bit disagrees with the ring polarity waits for the next cycle.
  assign net_si = ~reset & ~out_empty & (vc_of(out_head) == net_polarity);
  assign net_di = (reset | out_empty) ? '0 : out_head;
  assign net_ro = ~reset & ~in_full;

  ring_nic_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_out),
    .din_i   (d_in),
    .pop_i   (net_si & net_ri),
    .full_o  (out_full),
    .empty_o (out_empty),
    .head_o  (out_head)
  );

  ring_nic_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_in_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (net_so & net_ro),
    .din_i   (net_do),
    .pop_i   (rd_in),
    .full_o  (in_full),
    .empty_o (in_empty),
    .head_o  (in_head)
  );

`ifdef RING_NIC_STATS_EN
  logic [CNT_W-1:0] tx_q, tx_d, rx_q, rx_d, drop_q, drop_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && c != '1) ? c + 1'b1 : c;
  endfunction

  always_comb begin
    tx_d   = sat_inc(tx_q, net_si & net_ri);
    rx_d   = sat_inc(rx_q, net_so & net_ro);
    drop_d = sat_inc(drop_q, wr_out & out_full);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q   <= '0;
      rx_q   <= '0;
      drop_q <= '0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      drop_q <= drop_d;
    end
  end
`endif

  // NOTE: every path starts from a zero default, so no latch is inferred.
  always_comb begin
    d_out = '0;
    if (~reset && rd_en) begin
      unique case (addr_e'(addr))
        ADDR_IN_DATA:  d_out = in_empty ? '0 : in_head;
        ADDR_IN_STAT: begin
          d_out[0] = ~in_empty;
`ifdef RING_NIC_STATS_EN
          d_out[63:48] = 16'(rx_q);
          d_out[47:32] = 16'(drop_q);
`endif
        end
        ADDR_OUT_STAT: begin
          d_out[0] = out_full;
`ifdef RING_NIC_STATS_EN
          d_out[63:48] = 16'(tx_q);
`endif
        end
        default:       d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Directed self-checking bench for ring_nic (DEPTH = 2); works with or without RING_NIC_STATS_EN.
module tb_ring_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic        nicEn, nicWrEn;
  logic [63:0] d_out;
  logic        net_si, net_ri;
  logic [63:0] net_di;
  logic        net_so, net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int total = 0;
  int bad   = 0;

`ifdef RING_NIC_STATS_EN
  localparam logic [63:0] STAT_MASK = 64'h1;
`else
  localparam logic [63:0] STAT_MASK = '1;
`endif

  ring_nic #(.DEPTH(2), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .d_out        (d_out),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; polarity flips every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
    #1;
  endtask

  logic [63:0] got [$];
  localparam logic [63:0] PK_A = 64'h8000_0000_0000_00AA;
  localparam logic [63:0] P1   = 64'h0000_0000_0000_0011;
  localparam logic [63:0] P2   = 64'h8000_0000_0000_0022;
  localparam logic [63:0] P3   = 64'h0000_0000_0000_0033;

  initial begin
    reset = 1'b1; net_ri = 1'b0; net_so = 1'b0; net_do = '0; net_polarity = 1'b0;
    idle();

    // 1. Reset and idle.
    tick();
    rd(2'b01);
    check("ro_in_reset", {63'd0, net_ro}, 64'd0);
    check("dout_in_reset", d_out, 64'd0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("si_idle", {63'd0, net_si}, 64'd0);
    check("ro_idle", {63'd0, net_ro}, 64'd1);
    check("di_idle", net_di, 64'd0);
    rd(2'b01);
    check("in_stat_idle", d_out, 64'd0);
    rd(2'b11);
    check("out_stat_idle", d_out, 64'd0);
    rd(2'b00);
    check("in_data_empty", d_out, 64'd0);

    // 2. Single inject waits for matching polarity.
    net_ri = 1'b1;
    wr(2'b10, PK_A);
    tick();
    idle();
    #1;
    if (!net_polarity) begin
      check("si_wrong_pol", {63'd0, net_si}, 64'd0);
      tick();
      #1;
    end
    check("si_right_pol", {63'd0, net_si}, 64'd1);
    check("di_pkt", net_di, PK_A);
    tick();
    #1;
    check("si_after_tx", {63'd0, net_si}, 64'd0);
    check("di_after_tx", net_di, 64'd0);
    rd(2'b11);
    check("out_stat_after_tx", d_out & STAT_MASK, 64'd0);

    // 3. Overfill output FIFO with router blocked.
    net_ri = 1'b0;
    wr(2'b10, P1); tick();
    wr(2'b10, P2); tick();
    rd(2'b11);
    check("out_full", d_out & STAT_MASK, 64'd1);
    wr(2'b10, P3); tick();
    rd(2'b10);
    check("rd_out_data_zero", d_out, 64'd0);
    idle();
    net_ri = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (net_si && net_ri) got.push_back(net_di);
      tick();
    end
    check("tx_count", 64'(got.size()), 64'd2);
    check("tx_first", (got.size() > 0) ? got[0] : 64'hx, P1);
    check("tx_second", (got.size() > 1) ? got[1] : 64'hx, P2);
    rd(2'b11);
    check("out_stat_drained", d_out & STAT_MASK, 64'd0);
    idle();

    // 4. Eject two packets, drain via processor.
    net_so = 1'b1; net_do = 64'h1234; tick();
    net_do = 64'h5678; tick();
    net_so = 1'b0;
    rd(2'b01);
    check("in_stat_nonempty", d_out & STAT_MASK, 64'd1);
    rd(2'b00);
    check("rx_first", d_out, 64'h1234);
    tick();
    rd(2'b00);
    check("rx_second", d_out, 64'h5678);
    tick();
    rd(2'b01);
    check("in_stat_drained", d_out & STAT_MASK, 64'd0);
    idle();

    // 5. Full input FIFO: same-cycle pop does not admit a new packet.
    net_so = 1'b1; net_do = 64'hA1; tick();
    net_do = 64'hB2; tick();
    net_so = 1'b0;
    #1;
    check("ro_full", {63'd0, net_ro}, 64'd0);
    net_so = 1'b1; net_do = 64'hC3;
    rd(2'b00);
    check("pop_while_full", d_out, 64'hA1);
    check("ro_still_low", {63'd0, net_ro}, 64'd0);
    tick();
    net_so = 1'b0;
    idle();
    #1;
    check("ro_after_pop", {63'd0, net_ro}, 64'd1);
    rd(2'b00);
    check("rx_b2", d_out, 64'hB2);
    tick();
    rd(2'b01);
    check("c3_not_pushed", d_out & STAT_MASK, 64'd0);
    idle();

    // 6. Reset with both FIFOs partly occupied.
    net_ri = 1'b0;
    wr(2'b10, P1); tick();
    wr(2'b10, P2); tick();
    idle();
    net_so = 1'b1; net_do = 64'hD4; tick();
    net_so = 1'b0;
    reset = 1'b1;
    rd(2'b00);
    check("dout_reset_mid", d_out, 64'd0);
    tick();
    reset = 1'b0;
    net_ri = 1'b1;
    idle();
    #1;
    check("si_post_reset", {63'd0, net_si}, 64'd0);
    check("di_post_reset", net_di, 64'd0);
    check("ro_post_reset", {63'd0, net_ro}, 64'd1);
    rd(2'b01);
    check("in_stat_post_reset", d_out, 64'd0);
    rd(2'b11);
    check("out_stat_post_reset", d_out, 64'd0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
